// File: rtl/excp_unit_if.sv
// Instruction and CSR bus of the exception collection stage.
//   in_valid     : instruction present at the stage input
//   in_pc        : instruction pc
//   in_excp      : {ale, adef, ine, brk, sys, ertn} from upstream stages
//   in_priv      : instruction is privileged
//   in_error_va  : faulting data address for ALE
//   csr_vec      : one-shot exception vector to the CSR unit
//   csr_pc       : pc of the excepting instruction
//   csr_error_va : bad VA to the CSR unit
// master = pipeline side (drives the instruction, reads the CSR view),
// slave  = excp_unit.
interface excp_unit_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [5:0]  in_excp;
  logic        in_priv;
  logic [31:0] in_error_va;
  logic [63:0] csr_vec;
  logic [31:0] csr_pc;
  logic [31:0] csr_error_va;

  modport master (
    output in_valid, in_pc, in_excp, in_priv, in_error_va,
    input  csr_vec, csr_pc, csr_error_va
  );

  modport slave (
    input  in_valid, in_pc, in_excp, in_priv, in_error_va,
    output csr_vec, csr_pc, csr_error_va
  );
endinterface

// File: rtl/excp_unit.sv
// Exception/interrupt collection stage in front of the CSR unit.
// Captures one instruction per unstalled cycle, merges its exception flags,
// adds the privilege check (ipe) and the interrupt tag, and emits a one-shot
// vector {ale, adef, ipe, ine, brk, sys, ertn, int} the cycle after capture.
// A non-zero vector starts a redirect: flush stays high until fetch accepts
// the new pc.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   stall          : holds the stage register and the FSM
//   plv            : current privilege level
//   has_int        : CSR reports an enabled, pending interrupt
//   hw_int         : asynchronous interrupt lines
//   fetch_ack      : fetch accepted the redirect pc
//   bus            : instruction in / CSR out (excp_unit_if.slave)
//   hw_int_sync    : synchronised interrupt lines
//   flush          : kill all younger pipeline stages
//   redirect_busy  : FSM state (1 = REDIRECT); doubles as the state debug view
//
// Handshakes: an instruction is transferred when in_valid=1 and stall=0
// (stall is the inverted ready); a redirect is a request held by flush=1
// until the cycle with fetch_ack=1 and stall=0, after which flush drops.
module excp_unit #(
  parameter int NUM_HWI     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         plv,
  input  logic               has_int,
  input  logic [NUM_HWI-1:0] hw_int,
  input  logic               fetch_ack,
  excp_unit_if.slave         bus,
  output logic [NUM_HWI-1:0] hw_int_sync,
  output logic               flush,
  output logic               redirect_busy
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        stage_valid_q;
  logic [31:0] stage_pc_q;
  logic [31:0] stage_va_q;
  logic [7:0]  stage_flags_q;
  logic [7:0]  cap_flags;
  logic [7:0]  emit_flags;
  logic        f_ale, f_adef, f_ipe, f_ine, f_brk, f_sys, f_ertn, f_int;

  // Flag merge and priority masking at capture time, so the stage register
  // already holds the final vector.
  always_comb begin
    f_ale  = bus.in_excp[5];
    f_adef = bus.in_excp[4];
    f_ine  = bus.in_excp[3];
    f_brk  = bus.in_excp[2];
    f_sys  = bus.in_excp[1];
    f_ertn = bus.in_excp[0];
    // An undefined instruction cannot also be judged for privilege.
    f_ipe  = bus.in_priv & (plv != 2'd0) & ~f_ine;
    // The interrupt rides on the instruction instead of replacing it.
    f_int  = bus.in_valid & has_int & (state_q == S_IDLE);
    if (f_adef) begin
      // A bad fetch address makes the rest of the decode meaningless.
      f_ale  = 1'b0;
      f_ipe  = 1'b0;
      f_ine  = 1'b0;
      f_brk  = 1'b0;
      f_sys  = 1'b0;
      f_ertn = 1'b0;
    end
    if (f_ale | f_adef | f_ipe | f_ine | f_brk | f_sys) begin
      f_ertn = 1'b0;
    end
    cap_flags = {f_ale, f_adef, f_ipe, f_ine, f_brk, f_sys, f_ertn, f_int};
  end

  // Emission only on an unstalled IDLE cycle gives exactly one pulse per event.
  always_comb begin
    emit_flags = 8'd0;
    if (stage_valid_q && !stall && (state_q == S_IDLE)) begin
      emit_flags = stage_flags_q;
    end
  end

  // flush is raised in the emitting cycle itself so the instruction entering
  // the stage right now is already killed.
  assign flush         = (state_q == S_REDIRECT) | (emit_flags != 8'd0);
  assign redirect_busy = (state_q == S_REDIRECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_pc_q    <= '0;
      stage_va_q    <= '0;
      stage_flags_q <= '0;
    end else if (!stall) begin
      stage_valid_q <= bus.in_valid & ~flush;
      stage_pc_q    <= bus.in_pc;
      stage_va_q    <= bus.in_error_va;
      stage_flags_q <= cap_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (emit_flags != 8'd0) state_d = S_REDIRECT;
      S_REDIRECT: if (!stall && fetch_ack) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign bus.csr_vec      = {56'd0, emit_flags};
  assign bus.csr_pc       = stage_pc_q;
  assign bus.csr_error_va = stage_flags_q[7] ? stage_va_q : 32'd0;

  // Interrupt synchroniser: free-running, independent of stall.
  logic [NUM_HWI-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_int_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: doc/excp_unit.md
Name: excp_unit

Overview:
- Exception/interrupt collection stage sitting directly upstream of the CSR unit, between the EX/MEM pipeline boundary and the CSR block.
- Merges per-instruction exception flags carried down the pipeline, applies the privilege check (IPE), and tags the oldest valid instruction with a pending interrupt.
- Delivers a one-shot 64-bit exception vector plus pc and bad VA to the CSR unit.
- Runs a redirect FSM that flushes younger instructions until fetch accepts the new pc.

Parameters:
- NUM_HWI, 8, number of hardware interrupt lines synchronised by this block.
- SYNC_STAGES, 2, flip-flop stages in the interrupt synchroniser (≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  pipeline/AXI stall; holds all stage registers
- in_valid  in  1  instruction present at stage input
- in_pc  in  32  instruction pc
- in_excp  in  6  {ale, adef, ine, brk, sys, ertn} from upstream stages
- in_priv  in  1  instruction is privileged (csr*, ertn, idle, tlb*, cacop)
- in_error_va  in  32  faulting data address for ALE
- plv  in  2  current privilege level from CSR
- has_int  in  1  CSR reports enabled, pending interrupt
- hw_int  in  NUM_HWI  asynchronous external interrupt lines
- fetch_ack  in  1  fetch accepted the redirect pc
- csr_vec  out  64  bit7..0 = {ale, adef, ipe, ine, brk, sys, ertn, int}; bits 63:8 = 0
- csr_pc  out  32  pc of the excepting instruction
- csr_error_va  out  32  bad VA to the CSR
- hw_int_sync  out  NUM_HWI  synchronised interrupt lines, to ESTAT.IS[9:2]
- flush  out  1  kill all younger pipeline stages
- redirect_busy  out  1  FSM in REDIRECT

Behaviour:
- Reset: all stage registers 0; csr_vec=0, csr_pc=0, csr_error_va=0, flush=0, redirect_busy=0, hw_int_sync=0; FSM=IDLE; synchroniser cleared.
- Stage register: when !stall, captures in_valid (forced 0 in REDIRECT), in_pc, in_excp, in_error_va, ipe=in_priv & (plv!=0). When stall is high, all stage registers hold.
- Interrupt tag: int bit is set on capture iff in_valid & has_int & FSM==IDLE. The instruction is tagged, not dropped.
- Masking:
  - If adef=1, the other flags except int are cleared.
  - If ertn=1 together with any exception flag, ertn is cleared.
  - ipe is cleared when ine=1.
- Output gating: csr_vec[7:0] = stage flags when stage_valid & !stall & FSM==IDLE, else 0. csr_vec is non-zero for exactly one unstalled cycle per event.
- csr_pc and csr_error_va are driven from the stage registers continuously. csr_error_va = 0 unless ale=1.
- Latency: an instruction presented at cycle N (no stall) drives csr_vec in cycle N+1.
- FSM:
  - IDLE -> REDIRECT when csr_vec[7:0]!=0 in this cycle.
  - REDIRECT: flush=1, redirect_busy=1, stage_valid forced 0 on next capture.
  - REDIRECT -> IDLE on fetch_ack=1; flush drops the cycle after the ack.
- flush is also asserted combinationally in the IDLE cycle that emits a non-zero csr_vec, so younger stages are killed the same cycle.
- fetch_ack in IDLE is ignored.
- stall in REDIRECT: FSM holds; flush stays 1.
- Synchroniser: SYNC_STAGES-deep shift per line, free-running (not affected by stall). Output latency is SYNC_STAGES cycles.
- reset mid-REDIRECT returns to IDLE next edge with flush=0.

Test Plan:
- ALE: in_valid=1, in_excp.ale=1, in_pc=0x1c000100, in_error_va=0x00000003 -> next cycle csr_vec=0x80, csr_pc=0x1c000100, csr_error_va=0x3, flush=1. Then REDIRECT until fetch_ack; flush falls one cycle after the ack.
- Priority: adef+sys+has_int on the same instruction -> csr_vec=0x41 (adef, int). ertn+ine -> csr_vec=0x10.
- IPE: in_priv=1, plv=3 -> csr_vec=0x20. Same instruction with plv=0 -> csr_vec=0, no flush.
- Stall: excepting instruction captured, stall=1 for 3 cycles -> csr_vec=0 during the stall. One cycle of 0x04 (sys) after stall releases; FSM enters REDIRECT once.
- Squash: three in_valid instructions with sys flags back-to-back -> only the first produces csr_vec. The following two see stage_valid=0 while in REDIRECT.
- Sync: hw_int[3] rises at cycle 0 -> hw_int_sync[3]=1 at cycle 2 (SYNC_STAGES=2). reset in REDIRECT -> flush=0, FSM IDLE next cycle.
